r5p_lsu: RTL and testbench

- Load/store unit directly downstream of the R5P ALU.
- Takes the ALU `sum` result as the effective address and `rs2` as store data, and issues a single transfer on the data bus (valid/ready request phase, read data one cycle after the transfer).
- Aligns load data, then sign- or zero-extends it, and returns it to the writeback stage as a one-cycle response pulse.
- Multi-cycle and unpipelined: one access in flight.

---
 rtl/r5p_lsu.sv | 153 +++++++++++++++
 tb/tb_r5p_lsu.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/r5p_lsu.sv
// R5P load/store unit: one unpipelined data-bus access per request, with load alignment and extension.
// Optional misaligned-access trap enabled by defining R5P_LSU_MISALIGNED_EN.
module r5p_lsu #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned BW   = XLEN/8
)(
    input  logic            clk,
    input  logic            rst,
    input  logic            req_vld,
    output logic            req_rdy,
    input  logic            req_wen,
    input  logic [1:0]      req_siz,
    input  logic            req_uns,
    input  logic [XLEN-1:0] req_adr,
    input  logic [XLEN-1:0] req_wdt,
    output logic            ls_vld,
    input  logic            ls_rdy,
    output logic            ls_wen,
    output logic [XLEN-1:0] ls_adr,
    output logic [BW-1:0]   ls_ben,
    output logic [XLEN-1:0] ls_wdt,
    input  logic [XLEN-1:0] ls_rdt,
    output logic            rsp_vld,
    output logic [XLEN-1:0] rsp_rdt,
    output logic            rsp_mal
);
    localparam int unsigned OW = $clog2(BW);

    typedef enum logic [1:0] {IDLE, ADR, DAT, RSP} state_t;

    state_t          state_q, state_d;
    logic            wen_q, wen_d, uns_q, uns_d, mal_q, mal_d, rsp_vld_q, rsp_vld_d;
    logic [1:0]      siz_q, siz_d;
    logic [OW-1:0]   off_q, off_d;
    logic [XLEN-1:0] adr_q, adr_d, wdt_q, wdt_d, rdt_q, rdt_d;
    logic [BW-1:0]   ben_q, ben_d;

    logic [3:0]      nbytes_c;
    logic [OW-1:0]   amask_c, off_c;
    logic            ill_c, mal_c;
    logic [BW-1:0]   ben_c;
    logic [XLEN-1:0] wsh_c, wdt_c;

    // Request decode: lane offset, byte enables, lane-shifted store data
    always_comb begin
        nbytes_c = 4'd1 << req_siz;
        amask_c  = OW'(nbytes_c - 4'd1);
        ill_c    = (XLEN == 32) && (req_siz == 2'd3);
`ifdef R5P_LSU_MISALIGNED_EN
        off_c    = req_adr[OW-1:0];
        mal_c    = ill_c | (|(req_adr[OW-1:0] & amask_c));
`else
        off_c    = req_adr[OW-1:0] & ~amask_c;
        mal_c    = ill_c;
`endif
        ben_c    = BW'((16'd1 << nbytes_c) - 16'd1) << off_c;
        wsh_c    = req_wdt << {off_c, 3'b000};
        for (int i = 0; i < int'(BW); i++) begin
            wdt_c[8*i +: 8] = wsh_c[8*i +: 8] & {8{ben_c[i]}};
        end
    end

    logic [XLEN-1:0] tmp_c, keep_c, top_c, ext_c;
    logic [6:0]      nbits_c;

    // Load extraction: shift lane down, keep access width, sign/zero extend
    always_comb begin
        tmp_c   = ls_rdt >> {off_q, 3'b000};
        nbits_c = 7'd8 << siz_q;
        keep_c  = (32'(nbits_c) >= XLEN) ? '1 : ((XLEN'(1) << nbits_c) - XLEN'(1));
        top_c   = keep_c & ~(keep_c >> 1);
        ext_c   = (tmp_c & keep_c) | ((!uns_q && (|(tmp_c & top_c))) ? ~keep_c : '0);
    end

    always_comb begin
        state_d   = state_q;
        wen_d     = wen_q;
        siz_d     = siz_q;
        uns_d     = uns_q;
        off_d     = off_q;
        adr_d     = adr_q;
        ben_d     = ben_q;
        wdt_d     = wdt_q;
        mal_d     = mal_q;
        rdt_d     = rdt_q;
        unique case (state_q)
            IDLE: begin
                if (req_vld) begin
                    wen_d   = req_wen;
                    siz_d   = req_siz;
                    uns_d   = req_uns;
                    off_d   = off_c;
                    adr_d   = {req_adr[XLEN-1:OW], OW'(0)};
                    ben_d   = ben_c;
                    wdt_d   = wdt_c;
                    mal_d   = mal_c;
                    rdt_d   = '0;
                    state_d = mal_c ? RSP : ADR;
                end
            end
            ADR: begin
                if (ls_rdy) state_d = wen_q ? RSP : DAT;
            end
            DAT: begin
                rdt_d   = ext_c;
                state_d = RSP;
            end
            RSP: begin
                state_d = IDLE;
            end
        endcase
        rsp_vld_d = (state_d == RSP);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            wen_q     <= 1'b0;
            siz_q     <= 2'd0;
            uns_q     <= 1'b0;
            off_q     <= '0;
            adr_q     <= '0;
            ben_q     <= '0;
            wdt_q     <= '0;
            mal_q     <= 1'b0;
            rdt_q     <= '0;
            rsp_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wen_q     <= wen_d;
            siz_q     <= siz_d;
            uns_q     <= uns_d;
            off_q     <= off_d;
            adr_q     <= adr_d;
            ben_q     <= ben_d;
            wdt_q     <= wdt_d;
            mal_q     <= mal_d;
            rdt_q     <= rdt_d;
            rsp_vld_q <= rsp_vld_d;
        end
    end

    assign req_rdy = (state_q == IDLE);
    assign ls_vld  = (state_q == ADR);
    assign ls_wen  = wen_q;
    assign ls_adr  = adr_q;
    assign ls_ben  = ben_q;
    assign ls_wdt  = wdt_q;
    assign rsp_vld = rsp_vld_q;
    assign rsp_rdt = rdt_q;
    assign rsp_mal = mal_q;

endmodule

// File: tb/tb_r5p_lsu.sv
// Randomized bench for r5p_lsu (XLEN=32) against a byte-level reference model.
module tb_r5p_lsu;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_vld, req_rdy, req_wen, req_uns;
    logic [1:0]  req_siz;
    logic [31:0] req_adr, req_wdt;
    logic        ls_vld, ls_rdy, ls_wen;
    logic [31:0] ls_adr, ls_wdt, ls_rdt;
    logic [3:0]  ls_ben;
    logic        rsp_vld, rsp_mal;
    logic [31:0] rsp_rdt;

    int n_cmp = 0;
    int n_err = 0;

    r5p_lsu #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_wen(req_wen), .req_siz(req_siz),
        .req_uns(req_uns), .req_adr(req_adr), .req_wdt(req_wdt),
        .ls_vld(ls_vld), .ls_rdy(ls_rdy), .ls_wen(ls_wen), .ls_adr(ls_adr),
        .ls_ben(ls_ben), .ls_wdt(ls_wdt), .ls_rdt(ls_rdt),
        .rsp_vld(rsp_vld), .rsp_rdt(rsp_rdt), .rsp_mal(rsp_mal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One access; the model places bytes lane by lane from the access rules.
    task automatic access(input bit w, input logic [1:0] s, input bit u, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rd, input int stall);
        int          nb, off;
        bit          mal;
        logic [3:0]  eben;
        logic [31:0] ewdt, erdt;
        nb  = 1 << s;
        mal = (s == 2'd3);
`ifdef R5P_LSU_MISALIGNED_EN
        off = int'(a % 4);
        if ((a % nb) != 0) mal = 1'b1;
`else
        off = int'(a % 4) - (int'(a % 4) % nb);
`endif
        eben = '0; ewdt = '0; erdt = '0;
        for (int k = 0; k < nb; k++) begin
            if (off + k < 4) begin
                eben[off+k]          = 1'b1;
                ewdt[8*(off+k) +: 8] = wd[8*k +: 8];
                erdt[8*k +: 8]       = rd[8*(off+k) +: 8];
            end
        end
        if (!u && nb < 4 && erdt[8*nb-1]) erdt = erdt | ~((32'd1 << (8*nb)) - 32'd1);
        if (w) erdt = '0;

        @(negedge clk);
        chk("req_rdy_idle", req_rdy, 1);
        req_vld = 1'b1; req_wen = w; req_siz = s; req_uns = u; req_adr = a; req_wdt = wd;
        ls_rdy = (stall == 0); ls_rdt = $urandom;
        @(posedge clk); #1;
        if (mal) begin
            chk("mal_rsp_vld", rsp_vld, 1);
            chk("mal_flag", rsp_mal, 1);
            chk("mal_rdt", rsp_rdt, 0);
            chk("mal_no_bus", ls_vld, 0);
        end else begin
            for (int j = 0; j <= stall; j++) begin
                if (j > 0) begin @(posedge clk); #1; end
                chk("adr_ls_vld", ls_vld, 1);
                chk("adr_ls_wen", ls_wen, w);
                chk("adr_ls_adr", ls_adr, a & ~32'd3);
                chk("adr_ls_ben", ls_ben, eben);
                if (w) chk("adr_ls_wdt", ls_wdt, ewdt);
                chk("adr_busy", req_rdy, 0);
                chk("adr_no_rsp", rsp_vld, 0);
                @(negedge clk);
                ls_rdy = (j == stall); ls_rdt = $urandom;
                req_adr = $urandom; req_wdt = $urandom; req_wen = $urandom;
            end
            @(posedge clk); #1;
            if (!w) begin
                chk("dat_no_rsp", rsp_vld, 0);
                chk("dat_no_bus", ls_vld, 0);
                ls_rdt = rd;
                @(posedge clk); #1;
            end
            chk("rsp_vld", rsp_vld, 1);
            chk("rsp_mal", rsp_mal, 0);
            chk("rsp_rdt", rsp_rdt, erdt);
        end
        @(negedge clk);
        req_vld = 1'b0; ls_rdt = $urandom; ls_rdy = $urandom;
        @(posedge clk); #1;
        chk("rsp_pulse_end", rsp_vld, 0);
        chk("back_idle", req_rdy, 1);
    endtask

    initial begin
        rst = 1'b0; req_vld = 1'b0; req_wen = 1'b0; req_siz = 2'd0; req_uns = 1'b0;
        req_adr = '0; req_wdt = '0; ls_rdy = 1'b0; ls_rdt = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ls_vld", ls_vld, 0);
        chk("rst_rsp_vld", rsp_vld, 0);
        chk("rst_ls_adr", ls_adr, 0);
        chk("rst_ls_ben", ls_ben, 0);
        chk("rst_rsp_rdt", rsp_rdt, 0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_req_rdy", req_rdy, 1);

        access(1, 2'd2, 0, 32'h100, 32'hDEADBEEF, 32'h0, 0);
        access(0, 2'd0, 0, 32'h103, 32'h0, 32'h80112233, 0);
        access(0, 2'd0, 1, 32'h103, 32'h0, 32'h80112233, 0);
        access(1, 2'd1, 0, 32'h102, 32'h00001234, 32'h0, 0);
        access(0, 2'd1, 0, 32'h102, 32'h0, 32'h8765ABCD, 0);
        access(1, 2'd2, 0, 32'h200, 32'hCAFEF00D, 32'h0, 3);
        access(0, 2'd2, 0, 32'h101, 32'h0, 32'h13572468, 0);
        access(0, 2'd3, 0, 32'h108, 32'h0, 32'h11111111, 0);

        // Reset in the middle of a stalled access
        @(negedge clk);
        req_vld = 1'b1; req_wen = 1'b1; req_siz = 2'd2; req_adr = 32'h300; req_wdt = 32'h55AA55AA;
        ls_rdy = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_ls_vld", ls_vld, 1);
        @(negedge clk); req_vld = 1'b0; #1; rst = 1'b0; #1;
        chk("mid_rst_ls_vld", ls_vld, 0);
        chk("mid_rst_ls_adr", ls_adr, 0);
        chk("mid_rst_ls_ben", ls_ben, 0);
        chk("mid_rst_ls_wdt", ls_wdt, 0);
        chk("mid_rst_ls_wen", ls_wen, 0);
        chk("mid_rst_rsp_vld", rsp_vld, 0);
        @(negedge clk); rst = 1'b1; ls_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("post_rst_no_rsp", rsp_vld, 0);
            chk("post_rst_rdy", req_rdy, 1);
        end
        access(0, 2'd2, 0, 32'h0, 32'h0, 32'h89ABCDEF, 0);

        for (int i = 0; i < 200; i++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            access(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), a,
                   $urandom, $urandom, int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
